// File: rtl/lock_attempt_controller.sv
// Keypad lock controller: four-digit code entry, external compare, retry counting and timed lockout.
// Optional build macro LOCK_BACKDOOR_EN adds a fixed BACKDOOR_CODE that always grants in CHECK.
module lock_attempt_controller #(
  parameter int unsigned TICK_DIV    = 50000000,
  parameter int unsigned MAX_TRIES   = 3,
  parameter int unsigned LOCKOUT_SEC = 10
`ifdef LOCK_BACKDOOR_EN
  ,
  parameter logic [15:0] BACKDOOR_CODE = 16'hA5C3
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        ent,
  input  logic        clr,
  input  logic [3:0]  sw,
  input  logic        cmp_match,
  output logic [15:0] code,
  output logic        cmp_req,
  output logic [2:0]  digit_idx,
  output logic        busy,
  output logic        grant,
  output logic        deny,
  output logic [1:0]  fail_cnt,
  output logic        locked_out,
  output logic [7:0]  lockout_remain
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, ENTRY, CHECK, LOCKOUT} state_t;

  state_t              state, state_nxt;
  logic [TICK_W-1:0]   tick;
  logic                code_match;
  logic [1:0]          fail_next;
  logic                trip;
  logic                tick_wrap;

  function automatic logic [1:0] sat_inc(input logic [1:0] v);
    return (v == 2'd3) ? v : v + 2'd1;
  endfunction

  always_comb begin
    code_match = cmp_match;
`ifdef LOCK_BACKDOOR_EN
    if (code == BACKDOOR_CODE) code_match = 1'b1;
`endif
  end

  assign fail_next = sat_inc(fail_cnt);
  assign trip      = (fail_next == 2'(MAX_TRIES));
  assign tick_wrap = (tick == TICK_W'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ENTRY;
      ENTRY:   if (!clr && ent && digit_idx == 3'd3) state_nxt = CHECK;
      CHECK:   state_nxt = (!code_match && trip) ? LOCKOUT : IDLE;
      LOCKOUT: if (tick_wrap && lockout_remain == 8'd1) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath registers: code assembly, pulses, retry counter and lockout timer
  always_ff @(posedge clk) begin
    if (rst) begin
      code           <= '0;
      digit_idx      <= '0;
      grant          <= 1'b0;
      deny           <= 1'b0;
      fail_cnt       <= '0;
      lockout_remain <= '0;
      tick           <= '0;
    end else begin
      grant <= 1'b0;
      deny  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            code      <= '0;
            digit_idx <= '0;
          end
        end
        ENTRY: begin
          if (clr) begin
            code      <= '0;
            digit_idx <= '0;
          end else if (ent) begin
            case (digit_idx[1:0])
              2'd0:    code[15:12] <= sw;
              2'd1:    code[11:8]  <= sw;
              2'd2:    code[7:4]   <= sw;
              default: code[3:0]   <= sw;
            endcase
            digit_idx <= digit_idx + 3'd1;
          end
        end
        CHECK: begin
          if (code_match) begin
            grant    <= 1'b1;
            fail_cnt <= '0;
          end else begin
            deny     <= 1'b1;
            fail_cnt <= fail_next;
            if (trip) begin
              lockout_remain <= 8'(LOCKOUT_SEC);
              tick           <= '0;
            end
          end
        end
        LOCKOUT: begin
          if (tick_wrap) begin
            tick           <= '0;
            lockout_remain <= lockout_remain - 8'd1;
            if (lockout_remain == 8'd1) fail_cnt <= '0;
          end else begin
            tick <= tick + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Status flags decode from the state register only
  always_comb begin
    busy       = (state == ENTRY) || (state == CHECK);
    cmp_req    = (state == CHECK);
    locked_out = (state == LOCKOUT);
  end

endmodule

// File: tb/tb_lock_attempt_controller.sv
// Randomized self-checking bench for lock_attempt_controller (TICK_DIV=4, MAX_TRIES=3, LOCKOUT_SEC=2).
module tb_lock_attempt_controller;

  localparam int TD = 4;
  localparam int MT = 3;
  localparam int LS = 2;
  localparam int LOCK_CYC = TD * LS;
`ifdef LOCK_BACKDOOR_EN
  localparam bit BD = 1'b1;
`else
  localparam bit BD = 1'b0;
`endif

  logic        clk, rst, start, ent, clr, cmp_match;
  logic [3:0]  sw;
  logic [15:0] code;
  logic        cmp_req, busy, grant, deny, locked_out;
  logic [2:0]  digit_idx;
  logic [1:0]  fail_cnt;
  logic [7:0]  lockout_remain;

  int vectors = 0;
  int errors  = 0;

  lock_attempt_controller #(.TICK_DIV(TD), .MAX_TRIES(MT), .LOCKOUT_SEC(LS)) dut (
    .clk(clk), .rst(rst), .start(start), .ent(ent), .clr(clr), .sw(sw),
    .cmp_match(cmp_match), .code(code), .cmp_req(cmp_req), .digit_idx(digit_idx),
    .busy(busy), .grant(grant), .deny(deny), .fail_cnt(fail_cnt),
    .locked_out(locked_out), .lockout_remain(lockout_remain)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; ent = 1'b0; clr = 1'b0; cmp_match = 1'b0; sw = 4'h0;
    step();
    rst = 1'b0;
  endtask

  // Drives one complete entry, observes the CHECK cycle, then applies m and steps past CHECK.
  task automatic enter_code(input logic [15:0] c, input logic m,
                            output logic req_chk, output logic [15:0] code_chk);
    logic [15:0] cv;
    cv = c;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ent = 1'b1; sw = cv[15-4*i -: 4]; step();
    end
    ent = 1'b0;
    req_chk = cmp_req; code_chk = code;
    cmp_match = m; step(); cmp_match = 1'b0;
  endtask

  task automatic test_reset();
    start = 1'b1; ent = 1'b0; clr = 1'b0; cmp_match = 1'b0; sw = 4'h5; rst = 1'b0;
    step(); start = 1'b0; ent = 1'b1; step(); ent = 1'b0;
    do_reset();
    vectors++; if (code !== 16'h0) begin errors++; $display("FAIL reset_code: got %h want 0000", code); end
    vectors++; if (digit_idx !== 3'd0) begin errors++; $display("FAIL reset_idx: got %0d want 0", digit_idx); end
    vectors++; if ({cmp_req, busy, grant, deny, locked_out} !== 5'b0) begin errors++;
      $display("FAIL reset_flags: got %b want 00000", {cmp_req, busy, grant, deny, locked_out}); end
    vectors++; if ({fail_cnt, lockout_remain} !== 10'd0) begin errors++;
      $display("FAIL reset_counts: got fail=%0d remain=%0d want 0/0", fail_cnt, lockout_remain); end
  endtask

  task automatic test_grant();
    logic r; logic [15:0] cc;
    do_reset();
    enter_code(16'h1234, 1'b1, r, cc);
    vectors++; if (r !== 1'b1) begin errors++; $display("FAIL grant_cmp_req: got %b want 1", r); end
    vectors++; if (cc !== 16'h1234) begin errors++; $display("FAIL grant_code_chk: got %h want 1234", cc); end
    vectors++; if ({grant, deny, cmp_req, busy} !== 4'b1000) begin errors++;
      $display("FAIL grant_pulse: got g/d/req/busy=%b want 1000", {grant, deny, cmp_req, busy}); end
    vectors++; if (fail_cnt !== 2'd0) begin errors++; $display("FAIL grant_fail: got %0d want 0", fail_cnt); end
    step();
    vectors++; if ({grant, code} !== {1'b0, 16'h1234}) begin errors++;
      $display("FAIL grant_after: got grant=%b code=%h want 0 1234", grant, code); end
  endtask

  task automatic test_clr();
    do_reset();
    start = 1'b1; step(); start = 1'b0;
    ent = 1'b1; sw = 4'h7; step();
    sw = 4'h8; step();
    vectors++; if ({code, digit_idx} !== {16'h7800, 3'd2}) begin errors++;
      $display("FAIL clr_partial: got code=%h idx=%0d want 7800 2", code, digit_idx); end
    clr = 1'b1; sw = 4'h9; step(); clr = 1'b0; ent = 1'b0;
    vectors++; if ({code, digit_idx} !== {16'h0, 3'd0}) begin errors++;
      $display("FAIL clr_wins: got code=%h idx=%0d want 0000 0", code, digit_idx); end
    vectors++; if ({busy, cmp_req} !== 2'b10) begin errors++;
      $display("FAIL clr_stay_entry: got busy/req=%b want 10", {busy, cmp_req}); end
    start = 1'b1; step(); start = 1'b0;
    vectors++; if ({busy, digit_idx} !== {1'b1, 3'd0}) begin errors++;
      $display("FAIL entry_start_ignored: got busy=%b idx=%0d want 1 0", busy, digit_idx); end
  endtask

  task automatic test_lockout();
    logic r; logic [15:0] cc;
    do_reset();
    for (int i = 1; i <= MT; i++) begin
      enter_code(16'h0F00 + 16'(i), 1'b0, r, cc);
      vectors++; if ({deny, grant, fail_cnt} !== {1'b1, 1'b0, 2'(i)}) begin errors++;
        $display("FAIL lock_deny%0d: got deny=%b grant=%b fail=%0d want 1 0 %0d", i, deny, grant, fail_cnt, i); end
    end
    vectors++; if ({locked_out, busy, lockout_remain} !== {1'b1, 1'b0, 8'(LS)}) begin errors++;
      $display("FAIL lock_enter: got lock=%b busy=%b remain=%0d want 1 0 %0d", locked_out, busy, lockout_remain, LS); end
    for (int k = 1; k <= LOCK_CYC; k++) begin
      start = 1'b1; ent = 1'b1; sw = 4'(k); cmp_match = 1'b1;
      step();
      if (k == 1) begin
        vectors++; if (deny !== 1'b0) begin errors++; $display("FAIL lock_deny_once: got %b want 0", deny); end
      end
      if (k == TD) begin
        vectors++; if ({locked_out, lockout_remain} !== {1'b1, 8'd1}) begin errors++;
          $display("FAIL lock_remain1: got lock=%b remain=%0d want 1 1", locked_out, lockout_remain); end
      end
    end
    start = 1'b0; ent = 1'b0; cmp_match = 1'b0;
    vectors++; if ({locked_out, fail_cnt, lockout_remain, busy} !== 12'd0) begin errors++;
      $display("FAIL lock_exit: got lock=%b fail=%0d remain=%0d busy=%b want all 0", locked_out, fail_cnt, lockout_remain, busy); end
    step();
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL lock_start_ignored: got busy=%b want 0", busy); end
  endtask

  task automatic test_deny_then_grant();
    logic r; logic [15:0] cc;
    logic [1:0] expf [3];
    expf[0] = 2'd1; expf[1] = 2'd2; expf[2] = 2'd0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      enter_code(16'h4321, (i == 2), r, cc);
      vectors++; if ({fail_cnt, locked_out} !== {expf[i], 1'b0}) begin errors++;
        $display("FAIL dtg_step%0d: got fail=%0d lock=%b want %0d 0", i, fail_cnt, locked_out, expf[i]); end
    end
  endtask

  task automatic test_reset_in_lockout();
    logic r; logic [15:0] cc;
    do_reset();
    for (int i = 0; i < MT; i++) enter_code(16'h9999, 1'b0, r, cc);
    repeat (TD) step();
    vectors++; if (lockout_remain !== 8'd1) begin errors++;
      $display("FAIL rstlock_pre: got remain=%0d want 1", lockout_remain); end
    rst = 1'b1; step(); rst = 1'b0;
    vectors++; if ({code, digit_idx, cmp_req, busy, grant, deny, fail_cnt, locked_out, lockout_remain} !== 35'd0) begin errors++;
      $display("FAIL rstlock_outputs: got code=%h idx=%0d lock=%b fail=%0d remain=%0d want all 0",
               code, digit_idx, locked_out, fail_cnt, lockout_remain); end
    start = 1'b1; step(); start = 1'b0;
    vectors++; if ({busy, locked_out, digit_idx} !== {1'b1, 1'b0, 3'd0}) begin errors++;
      $display("FAIL rstlock_start: got busy=%b lock=%b idx=%0d want 1 0 0", busy, locked_out, digit_idx); end
  endtask

  task automatic test_backdoor();
    logic r; logic [15:0] cc;
    do_reset();
    enter_code(16'hA5C3, 1'b0, r, cc);
    vectors++; if ({grant, deny} !== {BD, !BD}) begin errors++;
      $display("FAIL backdoor: got grant=%b deny=%b want %b %b", grant, deny, BD, !BD); end
  endtask

  task automatic test_random();
    int m_fail;
    logic [15:0] m_code, val;
    logic [3:0] d;
    logic m, match, lock;
    int n, clears;
    do_reset();
    m_fail = 0; m_code = 16'h0;
    for (int t = 0; t < 40; t++) begin
      for (int g = $urandom_range(0, 3); g > 0; g--) begin
        ent = 1'($urandom); clr = 1'($urandom); sw = 4'($urandom);
        step();
        vectors++; if ({busy, code} !== {1'b0, m_code}) begin errors++;
          $display("FAIL rnd_idle_hold t%0d: got busy=%b code=%h want 0 %h", t, busy, code, m_code); end
      end
      ent = 1'b0; clr = 1'b0;
      start = 1'b1; step(); start = 1'b0;
      n = 0; val = 16'h0; clears = 0;
      while (n < 4) begin
        if (n > 0 && clears < 2 && $urandom_range(0, 5) == 0) begin
          clr = 1'b1; ent = 1'($urandom); sw = 4'($urandom);
          step(); clr = 1'b0; ent = 1'b0;
          n = 0; val = 16'h0; clears++;
          vectors++; if ({code, digit_idx} !== {16'h0, 3'd0}) begin errors++;
            $display("FAIL rnd_clr t%0d: got code=%h idx=%0d want 0000 0", t, code, digit_idx); end
        end else begin
          d = 4'($urandom);
          ent = 1'b1; sw = d; step(); ent = 1'b0;
          val = val * 16'd16 + 16'(d);
          n++;
          vectors++; if (digit_idx !== 3'(n)) begin errors++;
            $display("FAIL rnd_idx t%0d: got %0d want %0d", t, digit_idx, n); end
        end
      end
      vectors++; if ({cmp_req, code} !== {1'b1, val}) begin errors++;
        $display("FAIL rnd_check t%0d: got req=%b code=%h want 1 %h", t, cmp_req, code, val); end
      m = ($urandom_range(0, 3) == 0);
      cmp_match = m; step(); cmp_match = 1'b0;
      match = m || (BD && val == 16'hA5C3);
      m_fail = match ? 0 : ((m_fail < 3) ? m_fail + 1 : 3);
      lock = !match && (m_fail == MT);
      m_code = val;
      vectors++; if ({grant, deny, fail_cnt, locked_out, lockout_remain} !== {match, !match, 2'(m_fail), lock, lock ? 8'(LS) : 8'd0}) begin
        errors++;
        $display("FAIL rnd_result t%0d: got g=%b d=%b fail=%0d lock=%b rem=%0d want %b %b %0d %b %0d",
                 t, grant, deny, fail_cnt, locked_out, lockout_remain, match, !match, m_fail, lock, lock ? LS : 0);
      end
      if (lock) begin
        for (int k = 1; k <= LOCK_CYC; k++) begin
          start = 1'($urandom); ent = 1'($urandom); clr = 1'($urandom);
          sw = 4'($urandom); cmp_match = 1'($urandom);
          step();
          vectors++; if ({locked_out, lockout_remain} !== {(k < LOCK_CYC), (k < LOCK_CYC) ? 8'(LS - k / TD) : 8'd0}) begin
            errors++;
            $display("FAIL rnd_lock t%0d k%0d: got lock=%b rem=%0d want %b %0d", t, k, locked_out, lockout_remain,
                     (k < LOCK_CYC), (k < LOCK_CYC) ? LS - k / TD : 0);
          end
        end
        start = 1'b0; ent = 1'b0; clr = 1'b0; cmp_match = 1'b0;
        m_fail = 0;
        vectors++; if ({fail_cnt, busy} !== 3'b000) begin errors++;
          $display("FAIL rnd_unlock t%0d: got fail=%0d busy=%b want 0 0", t, fail_cnt, busy); end
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ent = 1'b0; clr = 1'b0; cmp_match = 1'b0; sw = 4'h0;
    test_reset();
    test_grant();
    test_clr();
    test_lockout();
    test_deny_then_grant();
    test_reset_in_lockout();
    test_backdoor();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/lock_attempt_controller.md
LOCK_ATTEMPT_CONTROLLER -- requirements
Module: lock_attempt_controller

Interface
REQ-001 Parameter TICK_DIV, default 50000000: clk cycles per one-second lockout tick, legal range 2..2^26.
REQ-002 Parameter MAX_TRIES, default 3: consecutive denials that trigger lockout, legal range 1..3.
REQ-003 Parameter LOCKOUT_SEC, default 10: lockout duration in ticks, legal range 1..255.
REQ-004 Port clk, input, 1: single clock; all state SHALL update on its rising edge only.
REQ-005 Port rst, input, 1: reset; synchronous and active-high.
REQ-006 Port start, input, 1: begin code entry; single-cycle pulse.
REQ-007 Port ent, input, 1: accept the current sw digit; single-cycle pulse.
REQ-008 Port clr, input, 1: discard the partially entered code; single-cycle pulse.
REQ-009 Port sw, input, 4: digit value.
REQ-010 Port cmp_match, input, 1: result from the external password comparator; valid in the cycle cmp_req=1.
REQ-011 Port code, output, 16: assembled code, first digit in [15:12].
REQ-012 Port cmp_req, output, 1: compare strobe.
REQ-013 Port digit_idx, output, 3: count of digits entered, 0..4.
REQ-014 Port busy, output, 1: high in ENTRY or CHECK.
REQ-015 Port grant, output, 1: one-cycle pulse on an accepted code.
REQ-016 Port deny, output, 1: one-cycle pulse on a rejected code.
REQ-017 Port fail_cnt, output, 2: consecutive denials.
REQ-018 Port locked_out, output, 1: high in LOCKOUT.
REQ-019 Port lockout_remain, output, 8: ticks left in LOCKOUT; 0 otherwise.

Function
REQ-020 The FSM SHALL have exactly four states: IDLE, ENTRY, CHECK, LOCKOUT.
REQ-021 IDLE: start=1 SHALL move to ENTRY next cycle and clear code to 0 and digit_idx to 0; ent and clr SHALL be ignored.
REQ-022 ENTRY: ent=1 with digit_idx=k SHALL write sw into code[15-4k -: 4] and increment digit_idx.
REQ-023 ENTRY: the ent that sets digit_idx to 4 SHALL move the FSM to CHECK next cycle.
REQ-024 ENTRY: clr=1 SHALL zero code and digit_idx and remain in ENTRY; clr SHALL win over a simultaneous ent.
REQ-025 ENTRY: start SHALL be ignored.
REQ-026 CHECK SHALL last exactly one cycle, with cmp_req=1 and code held stable; cmp_match SHALL be sampled in that cycle.
REQ-027 On match, grant SHALL be 1 in the following cycle, fail_cnt SHALL clear to 0, and the FSM SHALL enter IDLE.
REQ-028 On mismatch, deny SHALL be 1 in the following cycle and fail_cnt SHALL increment.
REQ-029 After a mismatch, if the new fail_cnt equals MAX_TRIES, the FSM SHALL enter LOCKOUT with lockout_remain=LOCKOUT_SEC and the tick counter at 0; otherwise it SHALL enter IDLE.
REQ-030 fail_cnt SHALL saturate and never wrap.
REQ-031 LOCKOUT: start, ent, clr, sw and cmp_match SHALL be ignored; locked_out=1.
REQ-032 LOCKOUT: the tick counter SHALL count 0..TICK_DIV-1 and wrap; lockout_remain SHALL decrement on each wrap.
REQ-033 LOCKOUT: when lockout_remain decrements to 0, the FSM SHALL enter IDLE and clear fail_cnt in that same edge.
REQ-034 code SHALL retain its value in IDLE until the next start.
REQ-035 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-036 With rst=1 at a clk edge, the FSM SHALL go to IDLE and code, digit_idx, cmp_req, busy, grant, deny, fail_cnt, locked_out, lockout_remain and the tick counter SHALL all be 0.
REQ-037 Reset SHALL abort any state, including mid-entry, CHECK and LOCKOUT, with no pending grant or deny pulse.

Configuration
REQ-038 Macro LOCK_BACKDOOR_EN, when defined, SHALL add parameter BACKDOOR_CODE (default 16'hA5C3).
REQ-039 With LOCK_BACKDOOR_EN defined, in CHECK, code==BACKDOOR_CODE SHALL be treated as a match regardless of cmp_match; it SHALL have no effect in LOCKOUT.
REQ-040 Without LOCK_BACKDOOR_EN, no backdoor logic SHALL exist and only cmp_match decides the result.

Verification (bench uses TICK_DIV=4, MAX_TRIES=3, LOCKOUT_SEC=2)
REQ-041 Sequence rst; start; ent with sw=1,2,3,4; cmp_match=1 in CHECK -> code=16'h1234, cmp_req high one cycle, grant one cycle, fail_cnt=0, FSM in IDLE.
REQ-042 start; ent sw=7; ent sw=8; clr and ent in the same cycle -> code=0, digit_idx=0, FSM in ENTRY.
REQ-043 Three full entries, each with cmp_match=0 -> deny pulses with fail_cnt 1, 2, 3; locked_out=1, lockout_remain=2; start/ent ignored; lockout_remain=1 after 4 cycles; IDLE and fail_cnt=0 after 8 cycles.
REQ-044 Two denials then one grant -> fail_cnt goes 1, 2, 0; no lockout.
REQ-045 rst asserted during LOCKOUT with lockout_remain=1 -> all outputs 0 next cycle; an immediate start is accepted.
REQ-046 LOCK_BACKDOOR_EN defined, entry A,5,C,3 with cmp_match=0 -> grant; undefined -> deny.
